// File: rtl/che_hist_cdf_knl_pkg.sv
// Shared constants, state encoding and helpers for the CLAHE histogram-to-LUT read side.
// The histogram kernel's common geometry lives here so every file of the slice agrees.
package che_hist_cdf_knl_pkg;

   localparam int GRAY_LEVEAL = 16;
   localparam int HIST_BIN_WD = 7;
   localparam int DAT_PIX_WD  = 5;
   localparam int TILE_SIZ    = 8;
   localparam int SIZ_FRA_X   = 64;
   localparam int EXC_WD      = 12;

   function automatic int LOG2(input int v);
      int n;
      n = 0;
      while ((1 << n) < v) n++;
      return n;
   endfunction

   localparam int GL_WD  = LOG2(GRAY_LEVEAL);
   localparam int LUT_WD = DAT_PIX_WD - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WAIT = 2'd2,
      ST_SCAN = 2'd3
   } state_e;

endpackage

// File: rtl/che_hist_cdf_lane.sv
// One lane: captures a clipped histogram plus its excess, spreads the excess over the bins
// and turns the running CDF into a registered, normalised mapping-LUT entry each scan cycle.
module che_hist_cdf_lane
   import che_hist_cdf_knl_pkg::*;
#(
   parameter int PIX_NUM = 64
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                i_cap,
   input  logic [GRAY_LEVEAL*HIST_BIN_WD-1:0]  i_hist,
   input  logic [EXC_WD-1:0]                   i_excess,
   input  logic                                i_scan,
   input  logic [GL_WD-1:0]                    i_k,
   output logic [LUT_WD-1:0]                   o_lut
);

   localparam int PIX_LG = LOG2(PIX_NUM);
   localparam int CDF_WD = PIX_LG + 1;
   localparam int Q_WD   = EXC_WD - GL_WD;
   localparam int SUM_WD = EXC_WD + 1;
   localparam int SC_WD  = CDF_WD + GL_WD + 1;

   logic [GRAY_LEVEAL*HIST_BIN_WD-1:0] r_hist;
   logic [Q_WD-1:0]                    r_q;
   logic [GL_WD-1:0]                   r_r;
   logic [CDF_WD-1:0]                  r_cdf;
   logic [LUT_WD-1:0]                  r_lut;

   logic [HIST_BIN_WD-1:0] w_hist_k;
   logic                   w_extra;
   logic [SUM_WD-1:0]      w_bin;
   logic [CDF_WD-1:0]      w_cdf_nxt;
   logic [SC_WD-1:0]       w_scaled;
   logic [SC_WD-1:0]       w_lut_raw;
   logic [LUT_WD-1:0]      w_lut;

   // Bins below the remainder absorb one extra count each.
   always_comb begin
      w_hist_k  = r_hist[i_k*HIST_BIN_WD +: HIST_BIN_WD];
      w_extra   = (i_k < r_r);
      w_bin     = SUM_WD'(w_hist_k) + SUM_WD'(r_q) + SUM_WD'(w_extra);
      w_cdf_nxt = r_cdf + CDF_WD'(w_bin);
      w_scaled  = SC_WD'(w_cdf_nxt) * SC_WD'(GRAY_LEVEAL - 1) + SC_WD'(PIX_NUM / 2);
      w_lut_raw = w_scaled >> PIX_LG;
      w_lut     = (w_lut_raw > SC_WD'(GRAY_LEVEAL - 1)) ? LUT_WD'(GRAY_LEVEAL - 1)
                                                        : w_lut_raw[LUT_WD-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= '0;
         r_q    <= '0;
         r_r    <= '0;
         r_cdf  <= '0;
         r_lut  <= '0;
      end else begin
         if (i_cap) begin
            r_hist <= i_hist;
            r_q    <= i_excess[EXC_WD-1:GL_WD];
            r_r    <= i_excess[GL_WD-1:0];
            r_cdf  <= '0;
         end else if (i_scan) begin
            r_cdf  <= w_cdf_nxt;
         end
         r_lut <= i_scan ? w_lut : '0;
      end
   end

   assign o_lut = r_lut;

endmodule

// File: rtl/che_hist_cdf_knl.sv
// Read side of the per-tile CLAHE histogram memory: issues one (single or pair) read,
// then streams one mapping-LUT entry per bin per cycle from two identical lanes.
module che_hist_cdf_knl
   import che_hist_cdf_knl_pkg::*;
#(
   parameter int TILE_X_NUM = SIZ_FRA_X / TILE_SIZ,
   parameter int PIX_NUM    = TILE_SIZ * TILE_SIZ
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start_i,
   input  logic [TILE_X_NUM-1:0]               tile_addr_i,
   input  logic                                double_i,
   output logic                                rd_en_o,
   output logic [TILE_X_NUM-1:0]               rd_addr_o,
   output logic                                rd_double_flg_o,
   input  logic                                vld_s0_i,
   input  logic                                vld_s1_i,
   input  logic [EXC_WD-1:0]                   express_bin_s0_i,
   input  logic [EXC_WD-1:0]                   express_bin_s1_i,
   input  logic [GRAY_LEVEAL*HIST_BIN_WD-1:0]  hist_s0_i,
   input  logic [GRAY_LEVEAL*HIST_BIN_WD-1:0]  hist_s1_i,
   output logic                                busy_o,
   output logic                                lut_wr_en_o,
   output logic                                lut_vld_s1_o,
   output logic [TILE_X_NUM-1:0]               lut_tile_o,
   output logic [LUT_WD-1:0]                   lut_idx_o,
   output logic [LUT_WD-1:0]                   lut_dat_s0_o,
   output logic [LUT_WD-1:0]                   lut_dat_s1_o,
   output logic                                done_o
);

   localparam logic [GL_WD-1:0] K_LAST = GL_WD'(GRAY_LEVEAL - 1);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [TILE_X_NUM-1:0] r_tile;
   logic                  r_double;
   logic [GL_WD-1:0]      r_k;
   logic                  r_wr_en;
   logic                  r_vld_s1;
   logic [GL_WD-1:0]      r_idx;
   logic                  r_done;

   logic w_start;
   logic w_rd_en;
   logic w_cap_s0;
   logic w_cap_s1;
   logic w_scan;
   logic w_scan_s1;

   // The registered LUT tail keeps busy high one cycle past SCAN, so start is masked there too.
   assign busy_o  = (r_state != ST_IDLE) | r_wr_en;
   assign w_start = start_i & ~busy_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = ST_RD;
         ST_RD:   w_state_nxt = ST_WAIT;
         ST_WAIT: if (vld_s0_i) w_state_nxt = ST_SCAN;
         ST_SCAN: if (r_k == K_LAST) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rd_en   = (r_state == ST_RD);
      w_cap_s0  = (r_state == ST_WAIT) & vld_s0_i;
      w_cap_s1  = w_cap_s0 & vld_s1_i & r_double;
      w_scan    = (r_state == ST_SCAN);
      w_scan_s1 = w_scan & r_double;
   end

   assign rd_en_o         = w_rd_en;
   assign rd_addr_o       = w_rd_en ? r_tile : '0;
   assign rd_double_flg_o = w_rd_en & r_double;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tile   <= '0;
         r_double <= 1'b0;
         r_k      <= '0;
         r_wr_en  <= 1'b0;
         r_vld_s1 <= 1'b0;
         r_idx    <= '0;
         r_done   <= 1'b0;
      end else begin
         if (w_start) begin
            r_tile   <= tile_addr_i;
            // The last tile of a row has no right-hand partner.
            r_double <= double_i & (tile_addr_i != TILE_X_NUM'(TILE_X_NUM - 1));
         end
         r_k      <= w_scan ? r_k + 1'b1 : '0;
         r_wr_en  <= w_scan;
         r_vld_s1 <= w_scan_s1;
         r_idx    <= w_scan ? r_k : '0;
         r_done   <= w_scan & (r_k == K_LAST);
      end
   end

   assign lut_wr_en_o  = r_wr_en;
   assign lut_vld_s1_o = r_vld_s1;
   assign lut_tile_o   = r_tile;
   assign lut_idx_o    = LUT_WD'(r_idx);
   assign done_o       = r_done;

   che_hist_cdf_lane #(.PIX_NUM(PIX_NUM)) u_lane_s0 (
      .clk      (clk),
      .rst      (rst),
      .i_cap    (w_cap_s0),
      .i_hist   (hist_s0_i),
      .i_excess (express_bin_s0_i),
      .i_scan   (w_scan),
      .i_k      (r_k),
      .o_lut    (lut_dat_s0_o)
   );

   che_hist_cdf_lane #(.PIX_NUM(PIX_NUM)) u_lane_s1 (
      .clk      (clk),
      .rst      (rst),
      .i_cap    (w_cap_s1),
      .i_hist   (hist_s1_i),
      .i_excess (express_bin_s1_i),
      .i_scan   (w_scan_s1),
      .i_k      (r_k),
      .o_lut    (lut_dat_s1_o)
   );

endmodule
